game_flow_controller: RTL and testbench

- Top-level game sequencer for the obstacle datapath (object position counter / game timer).
- Runs the MENU → PLAY → WON/LOST flow and drives the datapath's clear controls (menuScreen, playerWon, playerLost, reset_obj_count).
- Counts obstacles passed, lives and level, and latches the final game time on a win.
- Sits between the button/collision logic and the position counter.

---
 rtl/game_flow_controller.sv | 177 +++++++++++++++++
 tb/tb_game_flow_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// Game sequencer for the obstacle datapath: MENU -> PLAY (with HIT invulnerability) -> WON/LOST.
// Tracks obstacles passed, lives and level, and latches the final game time on a win.
module game_flow_controller #(
    parameter int WRAP_POS         = 680,
    parameter int PASSES_PER_LEVEL = 4,
    parameter int NUM_LEVELS       = 3,
    parameter int START_LIVES      = 3,
    parameter int HIT_CYCLES       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        collision,
    input  logic [9:0]  obj_position_counter,
    input  logic [15:0] game_time,
    output logic        menuScreen,
    output logic        playerWon,
    output logic        playerLost,
    output logic        reset_obj_count,
    output logic [2:0]  level,
    output logic [2:0]  lives,
    output logic [3:0]  passes,
    output logic        level_up,
    output logic [15:0] final_time
);

    localparam logic [2:0] ST_MENU = 3'd0;
    localparam logic [2:0] ST_PLAY = 3'd1;
    localparam logic [2:0] ST_HIT  = 3'd2;
    localparam logic [2:0] ST_WON  = 3'd3;
    localparam logic [2:0] ST_LOST = 3'd4;

    localparam logic [9:0] WRAP_V      = 10'(WRAP_POS);
    localparam logic [3:0] LAST_PASS_V = 4'(PASSES_PER_LEVEL - 1);
    localparam logic [2:0] LAST_LVL_V  = 3'(NUM_LEVELS - 1);
    localparam logic [2:0] LIVES_V     = 3'(START_LIVES);
    localparam logic [7:0] HIT_LOAD_V  = 8'(HIT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  level_q, level_d;
    logic [2:0]  lives_q, lives_d;
    logic [3:0]  passes_q, passes_d;
    logic [7:0]  hit_cnt_q, hit_cnt_d;
    logic        pass_armed_q, pass_armed_d;
    logic        start_prev_q;
    logic [15:0] final_time_q, final_time_d;
    logic        rst_obj_q, rst_obj_d;
    logic        level_up_q, level_up_d;
    logic        menu_q, won_q, lost_q;
    logic        start_rise_s;
    logic        at_wrap_s;

    assign start_rise_s = start_btn & ~start_prev_q;
    assign at_wrap_s    = (obj_position_counter >= WRAP_V);

    // Next-state and game-counter logic
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        lives_d      = lives_q;
        passes_d     = passes_q;
        hit_cnt_d    = hit_cnt_q;
        final_time_d = final_time_q;
        rst_obj_d    = 1'b0;
        level_up_d   = 1'b0;
        // Re-arm whenever the obstacle is back below the wrap point, in any state
        if (!at_wrap_s) begin
            pass_armed_d = 1'b1;
        end else begin
            pass_armed_d = pass_armed_q;
        end

        case (state_q)
            ST_MENU: begin
                if (start_rise_s) begin
                    state_d      = ST_PLAY;
                    lives_d      = LIVES_V;
                    level_d      = 3'd0;
                    passes_d     = 4'd0;
                    pass_armed_d = 1'b1;
                end else begin
                    state_d = ST_MENU;
                end
            end
            ST_PLAY: begin
                if (collision) begin
                    lives_d   = lives_q - 3'd1;
                    rst_obj_d = 1'b1;
                    if (lives_q == 3'd1) begin
                        state_d = ST_LOST;
                    end else begin
                        state_d   = ST_HIT;
                        hit_cnt_d = HIT_LOAD_V;
                    end
                end else if (at_wrap_s && pass_armed_q) begin
                    pass_armed_d = 1'b0;
                    if (passes_q == LAST_PASS_V) begin
                        passes_d  = 4'd0;
                        rst_obj_d = 1'b1;
                        if (level_q == LAST_LVL_V) begin
                            state_d      = ST_WON;
                            final_time_d = game_time;
                        end else begin
                            level_d    = level_q + 3'd1;
                            level_up_d = 1'b1;
                        end
                    end else begin
                        passes_d = passes_q + 4'd1;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (hit_cnt_q == 8'd0) begin
                    state_d = ST_PLAY;
                end else begin
                    hit_cnt_d = hit_cnt_q - 8'd1;
                end
            end
            ST_WON, ST_LOST: begin
                if (start_rise_s) begin
                    state_d = ST_MENU;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_MENU;
            level_q      <= 3'd0;
            lives_q      <= LIVES_V;
            passes_q     <= 4'd0;
            hit_cnt_q    <= 8'd0;
            pass_armed_q <= 1'b1;
            start_prev_q <= 1'b0;
            final_time_q <= 16'd0;
            rst_obj_q    <= 1'b0;
            level_up_q   <= 1'b0;
            menu_q       <= 1'b1;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            passes_q     <= passes_d;
            hit_cnt_q    <= hit_cnt_d;
            pass_armed_q <= pass_armed_d;
            start_prev_q <= start_btn;
            final_time_q <= final_time_d;
            rst_obj_q    <= rst_obj_d;
            level_up_q   <= level_up_d;
            menu_q       <= (state_d == ST_MENU);
            won_q        <= (state_d == ST_WON);
            lost_q       <= (state_d == ST_LOST);
        end
    end

    assign menuScreen      = menu_q;
    assign playerWon       = won_q;
    assign playerLost      = lost_q;
    assign reset_obj_count = rst_obj_q;
    assign level           = level_q;
    assign lives           = lives_q;
    assign passes          = passes_q;
    assign level_up        = level_up_q;
    assign final_time      = final_time_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: start, pass counting, collisions, lose, win, async reset.
module tb_game_flow_controller;

    logic        clk;
    logic        reset;
    logic        start_btn;
    logic        collision;
    logic [9:0]  obj_position_counter;
    logic [15:0] game_time;
    logic        menuScreen;
    logic        playerWon;
    logic        playerLost;
    logic        reset_obj_count;
    logic [2:0]  level;
    logic [2:0]  lives;
    logic [3:0]  passes;
    logic        level_up;
    logic [15:0] final_time;

    int total = 0;
    int bad   = 0;

    game_flow_controller dut (
        .clk                  (clk),
        .reset                (reset),
        .start_btn            (start_btn),
        .collision            (collision),
        .obj_position_counter (obj_position_counter),
        .game_time            (game_time),
        .menuScreen           (menuScreen),
        .playerWon            (playerWon),
        .playerLost           (playerLost),
        .reset_obj_count      (reset_obj_count),
        .level                (level),
        .lives                (lives),
        .passes               (passes),
        .level_up             (level_up),
        .final_time           (final_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk the obstacle from 0 up to just below the wrap point
    task automatic sweep();
        for (int p = 0; p < 680; p += 5) begin
            obj_position_counter = 10'(p);
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        start_btn = 1'b0;
        collision = 1'b0;
        obj_position_counter = 10'd0;
        game_time = 16'd0;
        repeat (3) tick();
        chk("rst_menu", 32'(menuScreen), 32'd1);
        chk("rst_won", 32'(playerWon), 32'd0);
        chk("rst_lost", 32'(playerLost), 32'd0);
        chk("rst_robj", 32'(reset_obj_count), 32'd0);
        chk("rst_lvlup", 32'(level_up), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_passes", 32'(passes), 32'd0);
        chk("rst_final", 32'(final_time), 32'd0);
        reset = 1'b1;
        tick();
        chk("menu_idle", 32'(menuScreen), 32'd1);

        // Start game, hold button
        start_btn = 1'b1;
        tick();
        chk("start_menu", 32'(menuScreen), 32'd0);
        chk("start_lives", 32'(lives), 32'd3);
        chk("start_level", 32'(level), 32'd0);
        repeat (10) tick();
        chk("hold_menu", 32'(menuScreen), 32'd0);
        chk("hold_robj", 32'(reset_obj_count), 32'd0);
        start_btn = 1'b0;

        // Pass 1 with dwell at 680 for three cycles
        sweep();
        obj_position_counter = 10'd680;
        repeat (3) tick();
        chk("dwell_passes", 32'(passes), 32'd1);
        obj_position_counter = 10'd0;
        tick();
        sweep();
        obj_position_counter = 10'd680;
        tick();
        chk("pass2", 32'(passes), 32'd2);
        obj_position_counter = 10'd0;
        tick();
        sweep();
        obj_position_counter = 10'd680;
        tick();
        chk("pass3", 32'(passes), 32'd3);
        chk("pass3_lvlup", 32'(level_up), 32'd0);
        obj_position_counter = 10'd0;
        tick();
        sweep();
        obj_position_counter = 10'd680;
        tick();
        chk("pass4_passes", 32'(passes), 32'd0);
        chk("pass4_level", 32'(level), 32'd1);
        chk("pass4_lvlup", 32'(level_up), 32'd1);
        chk("pass4_robj", 32'(reset_obj_count), 32'd1);
        obj_position_counter = 10'd0;
        tick();
        chk("pulse_end_lvlup", 32'(level_up), 32'd0);
        chk("pulse_end_robj", 32'(reset_obj_count), 32'd0);

        // Collision coincident with a pass: pass discarded
        collision = 1'b1;
        obj_position_counter = 10'd680;
        tick();
        chk("coinc_lives", 32'(lives), 32'd2);
        chk("coinc_passes", 32'(passes), 32'd0);
        chk("coinc_robj", 32'(reset_obj_count), 32'd1);
        collision = 1'b0;
        obj_position_counter = 10'd0;
        repeat (10) tick();

        // Held collision: one hit, 8 HIT cycles, then next hit on the 9th
        collision = 1'b1;
        tick();
        chk("hit2_lives", 32'(lives), 32'd1);
        repeat (8) tick();
        chk("invuln_lives", 32'(lives), 32'd1);
        chk("invuln_lost", 32'(playerLost), 32'd0);
        tick();
        chk("lose_lives", 32'(lives), 32'd0);
        chk("lose_flag", 32'(playerLost), 32'd1);
        chk("lose_robj", 32'(reset_obj_count), 32'd1);
        obj_position_counter = 10'd680;
        repeat (5) tick();
        chk("lost_lives_frozen", 32'(lives), 32'd0);
        chk("lost_passes_frozen", 32'(passes), 32'd0);
        chk("lost_level_frozen", 32'(level), 32'd1);
        chk("lost_flag_held", 32'(playerLost), 32'd1);
        collision = 1'b0;
        obj_position_counter = 10'd0;
        start_btn = 1'b1;
        tick();
        chk("lost_to_menu", 32'(menuScreen), 32'd1);
        chk("lost_cleared", 32'(playerLost), 32'd0);
        start_btn = 1'b0;
        tick();

        // New game for the win
        start_btn = 1'b1;
        tick();
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_level", 32'(level), 32'd0);
        start_btn = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            sweep();
            if (n == 12) game_time = 16'h01F4;
            obj_position_counter = 10'd680;
            tick();
            if (n == 8) chk("win_lvl2", 32'(level), 32'd2);
            obj_position_counter = 10'd0;
            if (n != 12) tick();
        end
        chk("win_flag", 32'(playerWon), 32'd1);
        chk("win_final", 32'(final_time), 32'h01F4);
        chk("win_level", 32'(level), 32'd2);
        chk("win_robj", 32'(reset_obj_count), 32'd1);
        chk("win_lvlup", 32'(level_up), 32'd0);
        game_time = 16'h0999;
        tick();
        chk("win_final_hold", 32'(final_time), 32'h01F4);
        start_btn = 1'b1;
        tick();
        chk("won_to_menu", 32'(menuScreen), 32'd1);
        chk("menu_final_kept", 32'(final_time), 32'h01F4);
        start_btn = 1'b0;
        tick();

        // Async reset while in HIT
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        collision = 1'b1;
        tick();
        chk("hit_pre_reset_lives", 32'(lives), 32'd2);
        collision = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_menu", 32'(menuScreen), 32'd1);
        chk("async_lives", 32'(lives), 32'd3);
        chk("async_final", 32'(final_time), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
